microwave_ctrl: RTL and testbench

Sequencing controller for the microwave's mm:ss countdown timer. It turns keypad digits into timer load pulses, clears the timer, and gates the timer's count enable from a 1 Hz tick. It drives the magnetron enable and the end-of-cook beeper from start, stop/clear and door inputs. It sits between the keypad/button front end and the three-digit timer block, and consumes the timer's `zero` flag.

---
 rtl/microwave_pkg.sv | 16 +
 rtl/microwave_ctrl_digit_entry.sv | 41 ++++
 rtl/microwave_ctrl.sv | 125 ++++++++++++
 tb/tb_microwave_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and defaults for the microwave cook-timer sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] KEY_MAX_DIGIT      = 4'd9;
  localparam int         DEFAULT_MAX_DIGITS = 3;
  localparam int         DEFAULT_BEEP_TICKS = 3;

endpackage

// File: rtl/microwave_ctrl_digit_entry.sv
// Keypad digit filter and counter; emits one-cycle timer load pulses.
module digit_entry
  import microwave_pkg::*;
#(
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       clear,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       key_accept,
  output logic [3:0] timer_data,
  output logic       timer_loadn
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  logic [CW-1:0] digit_cnt;

  assign key_accept = enable && key_valid && (key <= KEY_MAX_DIGIT) && (digit_cnt < MAX_CNT);

  always_ff @(posedge clock) begin
    if (clr) begin
      digit_cnt   <= '0;
      timer_data  <= 4'd0;
      timer_loadn <= 1'b1;
    end else begin
      timer_loadn <= !key_accept;
      if (clear) begin
        digit_cnt <= '0;
      end else if (key_accept) begin
        digit_cnt  <= digit_cnt + CW'(1);
        timer_data <= key;
      end
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Cook sequencer: keypad entry, start/pause/clear, magnetron gating and done beeper.
//
//   state | meaning
//   IDLE  | timer cleared, no digits entered
//   ENTRY | 1..MAX_DIGITS digits loaded into the timer
//   COOK  | magnetron on, ticks forwarded to timer
//   PAUSE | cooking suspended, timer digits held
//   DONE  | timer reached zero, beeping for BEEP_TICKS ticks
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS,
  parameter int BEEP_TICKS = DEFAULT_BEEP_TICKS
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clrn,
  output logic       timer_en,
  output logic       mag_on,
  output logic       beep
);

  localparam int BW = $clog2(BEEP_TICKS + 1);
  localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_TICKS);

  state_t        state, next_state;
  logic [BW-1:0] beep_cnt, beep_cnt_n;
  logic          clear_seq, en_n, entry_en, key_accept;

  // Keys only act when no higher-priority button shares the cycle.
  assign entry_en = ((state == IDLE) || (state == ENTRY)) && !stop_clear && !start;

  digit_entry #(.MAX_DIGITS(MAX_DIGITS)) u_digit_entry (
    .clock       (clock),
    .clr         (clr),
    .clear       (clear_seq),
    .enable      (entry_en),
    .key_valid   (key_valid),
    .key         (key),
    .key_accept  (key_accept),
    .timer_data  (timer_data),
    .timer_loadn (timer_loadn)
  );

  always_comb begin
    next_state = state;
    clear_seq  = 1'b0;
    en_n       = 1'b0;
    beep_cnt_n = beep_cnt;
    case (state)
      IDLE: begin
        if (key_accept) next_state = ENTRY;
      end
      ENTRY: begin
        if (stop_clear) begin
          clear_seq  = 1'b1;
          next_state = IDLE;
        end else if (start && door_closed && !timer_zero) begin
          next_state = COOK;
        end
      end
      COOK: begin
        if (!door_closed || stop_clear) begin
          next_state = PAUSE;
        end else if (timer_zero) begin
          next_state = DONE;
          beep_cnt_n = BEEP_LOAD;
        end else if (tick) begin
          en_n = 1'b1;
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          clear_seq  = 1'b1;
          next_state = IDLE;
        end else if (start && door_closed && !timer_zero) begin
          next_state = COOK;
        end
      end
      DONE: begin
        if (!door_closed || stop_clear) begin
          clear_seq  = 1'b1;
          next_state = IDLE;
        end else if (tick) begin
          // Down-counter terminal count: the last beep tick ends DONE.
          if (beep_cnt <= BW'(1)) begin
            clear_seq  = 1'b1;
            next_state = IDLE;
          end else begin
            beep_cnt_n = beep_cnt - BW'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state      <= IDLE;
      beep_cnt   <= '0;
      timer_clrn <= 1'b0;
      timer_en   <= 1'b0;
      mag_on     <= 1'b0;
      beep       <= 1'b0;
    end else begin
      state      <= next_state;
      beep_cnt   <= beep_cnt_n;
      timer_clrn <= !clear_seq;
      timer_en   <= en_n;
      mag_on     <= (next_state == COOK);
      beep       <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed bench for microwave_ctrl with a small mm:ss timer model on the outputs.
module tb_microwave_ctrl;

  logic       clock = 1'b0;
  logic       clr, tick, key_valid, start, stop_clear, door_closed;
  logic [3:0] key;
  logic       timer_zero;
  logic [3:0] timer_data;
  logic       timer_loadn, timer_clrn, timer_en, mag_on, beep;

  int errs   = 0;
  int checks = 0;

  // peer timer block: d2 = minutes, d1 = tens of seconds, d0 = seconds
  logic [3:0] d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  assign timer_zero = (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!timer_clrn) begin
      d2 <= 4'd0; d1 <= 4'd0; d0 <= 4'd0;
    end else if (!timer_loadn) begin
      d2 <= d1; d1 <= d0; d0 <= timer_data;
    end else if (timer_en && !timer_zero) begin
      if (d0 != 4'd0) d0 <= d0 - 4'd1;
      else begin
        d0 <= 4'd9;
        if (d1 != 4'd0) d1 <= d1 - 4'd1;
        else begin d1 <= 4'd5; d2 <= d2 - 4'd1; end
      end
    end
  end

  microwave_ctrl dut (
    .clock       (clock),
    .clr         (clr),
    .tick        (tick),
    .key_valid   (key_valid),
    .key         (key),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .timer_data  (timer_data),
    .timer_loadn (timer_loadn),
    .timer_clrn  (timer_clrn),
    .timer_en    (timer_en),
    .mag_on      (mag_on),
    .beep        (beep)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_key(input logic [3:0] k, input int exp_load, input string tag);
    key_valid = 1'b1; key = k;
    step();
    key_valid = 1'b0;
    chk({tag, "_loadn"}, timer_loadn, exp_load ? 0 : 1);
    if (exp_load) chk({tag, "_data"}, timer_data, k);
    step();
    chk({tag, "_loadn_end"}, timer_loadn, 1);
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  int en_count;

  initial begin
    clr = 1'b1; tick = 0; key_valid = 0; key = 0; start = 0; stop_clear = 0; door_closed = 1;
    step();
    chk("rst_data", timer_data, 0);
    chk("rst_loadn", timer_loadn, 1);
    chk("rst_clrn", timer_clrn, 0);
    chk("rst_en", timer_en, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_beep", beep, 0);
    clr = 1'b0;
    step();
    chk("rst_clrn_release", timer_clrn, 1);

    // invalid key code, then 1,3,0 and a rejected fourth digit
    press_key(4'd12, 0, "key12");
    press_key(4'd1, 1, "key1");
    press_key(4'd3, 1, "key3");
    press_key(4'd0, 1, "key0");
    press_key(4'd5, 0, "key4th");

    start = 1'b1; step(); start = 1'b0;
    chk("start_mag", mag_on, 1);

    // pause via stop_clear, then stop_clear+start together clears to IDLE
    stop_clear = 1'b1; step(); stop_clear = 1'b0;
    chk("pause_mag", mag_on, 0);
    chk("pause_clrn", timer_clrn, 1);
    stop_clear = 1'b1; start = 1'b1; step(); stop_clear = 1'b0; start = 1'b0;
    chk("sc_start_clrn", timer_clrn, 0);
    chk("sc_start_mag", mag_on, 0);
    step();
    chk("sc_start_clrn_end", timer_clrn, 1);
    chk("sc_start_mag2", mag_on, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("idle_start_ignored", mag_on, 0);
    press_key(4'd7, 1, "idle_key7");

    stop_clear = 1'b1; step(); stop_clear = 1'b0;
    chk("entry_clear_clrn", timer_clrn, 0);
    step();

    // all-zero entry cannot start
    press_key(4'd0, 1, "z0a");
    press_key(4'd0, 1, "z0b");
    start = 1'b1; step(); start = 1'b0;
    chk("zero_start_ignored", mag_on, 0);
    press_key(4'd2, 1, "z2");

    // cook 0:02 down to zero
    start = 1'b1; step(); start = 1'b0;
    chk("cook2_mag", mag_on, 1);
    en_count = 0;
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (timer_en) en_count++;
      chk("cook2_en_pulse", timer_en, 1);
      step();
      chk("cook2_en_low", timer_en, 0);
    end
    chk("cook2_en_count", en_count, 2);
    step();
    chk("done_beep", beep, 1);
    chk("done_mag", mag_on, 0);
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      chk("done_beep_hold", beep, 1);
      chk("done_no_en", timer_en, 0);
      step();
    end
    pulse_tick();
    chk("done_beep_end", beep, 0);
    chk("done_clrn", timer_clrn, 0);
    step();
    chk("done_clrn_end", timer_clrn, 1);
    chk("done_zero", timer_zero, 1);

    // door opened mid-cook at 0:45, tick in same cycle is dropped
    press_key(4'd0, 1, "k0");
    press_key(4'd4, 1, "k4");
    press_key(4'd5, 1, "k5");
    start = 1'b1; step(); start = 1'b0;
    chk("cook45_mag", mag_on, 1);
    door_closed = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    chk("door_mag", mag_on, 0);
    chk("door_en", timer_en, 0);
    step();
    pulse_tick();
    chk("door_tick_en", timer_en, 0);
    step();
    chk("held_45", {d2, d1, d0}, 12'h045);
    door_closed = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("resume_mag", mag_on, 1);
    pulse_tick();
    chk("resume_en", timer_en, 1);
    step();
    chk("resume_44", {d2, d1, d0}, 12'h044);

    // clr during cook
    clr = 1'b1; step();
    chk("clr_mag", mag_on, 0);
    chk("clr_clrn", timer_clrn, 0);
    chk("clr_loadn", timer_loadn, 1);
    chk("clr_en", timer_en, 0);
    chk("clr_beep", beep, 0);
    step();
    chk("clr_clrn_hold", timer_clrn, 0);
    clr = 1'b0; step();
    chk("clr_clrn_release", timer_clrn, 1);
    chk("clr_mag_after", mag_on, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
